// File: rtl/bp_be_pkg.sv
// Shared types and opcode classification for the dual-issue arbiter.
// The class decode is kept here so the pair checker and any future detector logic agree.
package bp_be_pkg;

  typedef enum logic [0:0] {e_iss_run, e_iss_wait} bp_be_dual_iss_state_e;

  typedef struct packed {
    logic mem;
    logic ser;
    logic ctl;
    logic wr_rd;
  } bp_be_iss_class_s;

  localparam logic [6:0] rv64_load_op     = 7'b0000011;
  localparam logic [6:0] rv64_store_op    = 7'b0100011;
  localparam logic [6:0] rv64_amo_op      = 7'b0101111;
  localparam logic [6:0] rv64_fload_op    = 7'b0000111;
  localparam logic [6:0] rv64_fstore_op   = 7'b0100111;
  localparam logic [6:0] rv64_system_op   = 7'b1110011;
  localparam logic [6:0] rv64_misc_mem_op = 7'b0001111;
  localparam logic [6:0] rv64_branch_op   = 7'b1100011;
  localparam logic [6:0] rv64_jal_op      = 7'b1101111;
  localparam logic [6:0] rv64_jalr_op     = 7'b1100111;

  function automatic bp_be_iss_class_s decode_iss_class(input logic [6:0] opcode);
    bp_be_iss_class_s c;
    c.mem   = (opcode == rv64_load_op)  || (opcode == rv64_store_op)
           || (opcode == rv64_amo_op)   || (opcode == rv64_fload_op)
           || (opcode == rv64_fstore_op);
    c.ser   = (opcode == rv64_system_op) || (opcode == rv64_misc_mem_op);
    c.ctl   = (opcode == rv64_branch_op) || (opcode == rv64_jal_op)
           || (opcode == rv64_jalr_op);
    // Stores and branches have no destination; everything else is treated as writing rd.
    c.wr_rd = !((opcode == rv64_store_op) || (opcode == rv64_fstore_op)
             || (opcode == rv64_branch_op));
    return c;
  endfunction

endpackage

// File: rtl/bp_be_pair_checker.sv
// Combinational pairing rules for the head and head+1 instructions.
// Register fields of slot1 are compared regardless of its format, which may block a legal pair.
module bp_be_pair_checker
  import bp_be_pkg::*;
#(
  parameter int instr_width_p = 32
) (
  input  logic [instr_width_p-1:0] instr0,
  input  logic [instr_width_p-1:0] instr1,
  output logic                     pair_ok,
  output bp_be_iss_class_s         class0,
  output bp_be_iss_class_s         class1
);

  logic [4:0] rd0;
  logic [4:0] rs1_1;
  logic [4:0] rs2_1;
  logic       raw_hazard;

  assign class0 = decode_iss_class(instr0[6:0]);
  assign class1 = decode_iss_class(instr1[6:0]);

  assign rd0   = instr0[11:7];
  assign rs1_1 = instr1[19:15];
  assign rs2_1 = instr1[24:20];

  assign raw_hazard = class0.wr_rd && (rd0 != 5'd0) && ((rs1_1 == rd0) || (rs2_1 == rd0));

  assign pair_ok = !class0.ser && !class1.ser
                && !(class0.mem && class1.mem)
                && !class0.ctl
                && !raw_hazard;

endmodule

// File: rtl/bp_be_dual_issue_arbiter.sv
// Issue-stage buffer between the FE queue and the scheduler: presents the head alone or
// the head pair, and stalls issue after a serializing instruction until it commits.
module bp_be_dual_issue_arbiter
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int depth_p       = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [1:0]                 fe_v_i,
  input  logic [2*vaddr_width_p-1:0] fe_pc_i,
  input  logic [2*instr_width_p-1:0] fe_instr_i,
  output logic                       fe_ready_o,
  output logic [1:0]                 iss_v_o,
  output logic [2*vaddr_width_p-1:0] iss_pc_o,
  output logic [2*instr_width_p-1:0] iss_instr_o,
  input  logic [1:0]                 iss_yumi_i,
  input  logic                       poison_i,
  input  logic                       suppress_i,
  input  logic                       serial_done_i,
  output logic [31:0]                pair_cnt_o
);

  localparam int ptr_w = $clog2(depth_p);
  localparam int cnt_w = $clog2(depth_p + 1);

  logic [vaddr_width_p-1:0] pc_mem    [depth_p];
  logic [instr_width_p-1:0] instr_mem [depth_p];

  logic [ptr_w-1:0] head_reg, tail_reg, tail1;
  logic [cnt_w-1:0] count_reg;
  logic [1:0]       push_v;
  logic [cnt_w-1:0] push_n, pop_n;
  logic [31:0]      pair_cnt_reg;

  bp_be_dual_iss_state_e state_reg, state_next;

  logic             pair_ok;
  bp_be_iss_class_s class0, class1;

  // Ready is computed from the registered count only, so a same-cycle pop never frees space early.
  assign fe_ready_o = (count_reg <= cnt_w'(depth_p - 2));
  assign push_v     = fe_v_i & {2{fe_ready_o && !poison_i}};
  assign push_n     = cnt_w'(push_v[0]) + cnt_w'(push_v[1]);
  assign pop_n      = cnt_w'(iss_yumi_i[0]) + cnt_w'(iss_yumi_i[1]);
  assign tail1      = tail_reg + ptr_w'(1);

  always_ff @(posedge clk_i) begin
    if (push_v[0]) begin
      pc_mem[tail_reg]    <= fe_pc_i[0 +: vaddr_width_p];
      instr_mem[tail_reg] <= fe_instr_i[0 +: instr_width_p];
    end
    if (push_v[1]) begin
      pc_mem[tail1]    <= fe_pc_i[vaddr_width_p +: vaddr_width_p];
      instr_mem[tail1] <= fe_instr_i[instr_width_p +: instr_width_p];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [ptr_w-1:0] rd_ptr;
      assign rd_ptr = head_reg + ptr_w'(gi);
      assign iss_pc_o[gi*vaddr_width_p +: vaddr_width_p]    = pc_mem[rd_ptr];
      assign iss_instr_o[gi*instr_width_p +: instr_width_p] = instr_mem[rd_ptr];
    end
  endgenerate

  bp_be_pair_checker #(
    .instr_width_p(instr_width_p)
  ) pair_checker (
    .instr0 (iss_instr_o[0 +: instr_width_p]),
    .instr1 (iss_instr_o[instr_width_p +: instr_width_p]),
    .pair_ok(pair_ok),
    .class0 (class0),
    .class1 (class1)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (poison_i) begin
      head_reg  <= tail_reg;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + ptr_w'(pop_n);
      tail_reg  <= tail_reg + ptr_w'(push_n);
      count_reg <= count_reg + push_n - pop_n;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg    <= e_iss_run;
      pair_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (iss_yumi_i == 2'b11 && pair_cnt_reg != '1) begin
        pair_cnt_reg <= pair_cnt_reg + 32'd1;
      end
    end
  end

  assign pair_cnt_o = pair_cnt_reg;

  always_comb begin
    state_next = state_reg;
    iss_v_o    = 2'b00;
    if (state_reg == e_iss_run && count_reg != '0 && !suppress_i && !poison_i) begin
      iss_v_o[0] = 1'b1;
      iss_v_o[1] = (count_reg >= cnt_w'(2)) && pair_ok;
    end
    case (state_reg)
      e_iss_run:  if (iss_yumi_i[0] && class0.ser) state_next = e_iss_wait;
      e_iss_wait: if (serial_done_i) state_next = e_iss_run;
      default:    state_next = e_iss_run;
    endcase
    if (poison_i) state_next = e_iss_run;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (fe_v_i != 2'b10);
      assert (iss_yumi_i != 2'b10);
      assert ((iss_yumi_i & ~iss_v_o) == 2'b00);
      assert (!((fe_v_i != 2'b00) && !fe_ready_o));
    end
  end

endmodule

// File: tb/tb_bp_be_dual_issue_arbiter.sv
// Directed bench for the dual-issue arbiter: pairing rules, serialization, buffer limits,
// poison, suppress and asynchronous reset.
module tb_bp_be_dual_issue_arbiter;

  localparam int VW = 39;
  localparam int IW = 32;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [1:0]        fe_v_i;
  logic [2*VW-1:0]   fe_pc_i;
  logic [2*IW-1:0]   fe_instr_i;
  logic              fe_ready_o;
  logic [1:0]        iss_v_o;
  logic [2*VW-1:0]   iss_pc_o;
  logic [2*IW-1:0]   iss_instr_o;
  logic [1:0]        iss_yumi_i;
  logic              poison_i;
  logic              suppress_i;
  logic              serial_done_i;
  logic [31:0]       pair_cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  bp_be_dual_issue_arbiter #(
    .vaddr_width_p(VW),
    .instr_width_p(IW),
    .depth_p(4)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .fe_v_i       (fe_v_i),
    .fe_pc_i      (fe_pc_i),
    .fe_instr_i   (fe_instr_i),
    .fe_ready_o   (fe_ready_o),
    .iss_v_o      (iss_v_o),
    .iss_pc_o     (iss_pc_o),
    .iss_instr_o  (iss_instr_o),
    .iss_yumi_i   (iss_yumi_i),
    .poison_i     (poison_i),
    .suppress_i   (suppress_i),
    .serial_done_i(serial_done_i),
    .pair_cnt_o   (pair_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push(input logic [1:0] v, input logic [VW-1:0] p0, input logic [IW-1:0] i0,
                      input logic [VW-1:0] p1, input logic [IW-1:0] i1);
    fe_v_i     = v;
    fe_pc_i    = {p1, p0};
    fe_instr_i = {i1, i0};
    tick();
    fe_v_i = 2'b00;
    $display("push v=%b pc0=%0h pc1=%0h -> iss_v=%b ready=%b", v, p0, p1, iss_v_o, fe_ready_o);
  endtask

  task automatic pop(input logic [1:0] y);
    iss_yumi_i = y;
    tick();
    iss_yumi_i = 2'b00;
    $display("pop yumi=%b -> iss_v=%b ready=%b pair_cnt=%0d", y, iss_v_o, fe_ready_o, pair_cnt_o);
  endtask

  logic [31:0] csr_i;
  logic [31:0] ld_i;
  logic [31:0] sd_i;

  initial begin
    csr_i = {12'h300, 5'd2, 3'b001, 5'd1, 7'b1110011};
    ld_i  = {12'h000, 5'd6, 3'b011, 5'd5, 7'b0000011};
    sd_i  = {7'b0, 5'd7, 5'd8, 3'b011, 5'b0, 7'b0100011};

    reset_i = 1'b1; fe_v_i = '0; fe_pc_i = '0; fe_instr_i = '0;
    iss_yumi_i = '0; poison_i = 1'b0; suppress_i = 1'b0; serial_done_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_iss_v", iss_v_o, 2'b00);
    check("rst_ready", fe_ready_o, 1'b1);
    check("rst_pair_cnt", pair_cnt_o, 32'd0);
    reset_i = 1'b0;
    tick();

    // Independent pair issues together.
    push(2'b11, 39'h100, add_i(5'd1, 5'd2, 5'd3), 39'h104, add_i(5'd4, 5'd5, 5'd6));
    check("pair_iss_v", iss_v_o, 2'b11);
    check("pair_iss_pc", iss_pc_o, {39'h104, 39'h100});
    pop(2'b11);
    check("pair_cnt_1", pair_cnt_o, 32'd1);
    check("pair_empty", iss_v_o, 2'b00);

    // RAW inside the pair splits it.
    push(2'b11, 39'h200, add_i(5'd1, 5'd2, 5'd3), 39'h204, add_i(5'd7, 5'd1, 5'd2));
    check("raw_iss_v", iss_v_o, 2'b01);
    check("raw_pc0", iss_pc_o[VW-1:0], 39'h200);
    pop(2'b01);
    check("raw_second_v", iss_v_o, 2'b01);
    check("raw_second_pc", iss_pc_o[VW-1:0], 39'h204);
    pop(2'b01);

    // Two memory ops never pair.
    push(2'b11, 39'h300, ld_i, 39'h304, sd_i);
    check("mem_iss_v", iss_v_o, 2'b01);
    pop(2'b01);
    check("mem_second_v", iss_v_o, 2'b01);
    check("mem_second_instr", iss_instr_o[IW-1:0], sd_i);
    pop(2'b01);

    // Serializing op blocks issue until commit.
    push(2'b11, 39'h400, csr_i, 39'h404, add_i(5'd3, 5'd4, 5'd5));
    check("ser_iss_v", iss_v_o, 2'b01);
    pop(2'b01);
    check("ser_wait_v", iss_v_o, 2'b00);
    tick();
    check("ser_wait_hold", iss_v_o, 2'b00);
    serial_done_i = 1'b1;
    tick();
    serial_done_i = 1'b0;
    check("ser_done_v", iss_v_o, 2'b01);
    check("ser_done_instr", iss_instr_o[IW-1:0], add_i(5'd3, 5'd4, 5'd5));
    pop(2'b01);

    // Suppress, buffer fill, and pointer wrap.
    push(2'b11, 39'h500, add_i(5'd10, 5'd11, 5'd12), 39'h504, add_i(5'd13, 5'd14, 5'd15));
    suppress_i = 1'b1;
    #1;
    check("suppress_v", iss_v_o, 2'b00);
    suppress_i = 1'b0;
    #1;
    check("unsuppress_v", iss_v_o, 2'b11);
    push(2'b01, 39'h508, add_i(5'd16, 5'd17, 5'd18), 39'h0, 32'h0);
    check("cnt3_ready", fe_ready_o, 1'b0);
    pop(2'b01);
    check("cnt2_ready", fe_ready_o, 1'b1);
    push(2'b11, 39'h50c, add_i(5'd19, 5'd21, 5'd22), 39'h510, add_i(5'd20, 5'd23, 5'd24));
    check("cnt4_ready", fe_ready_o, 1'b0);
    check("cnt4_pc", iss_pc_o, {39'h508, 39'h504});
    pop(2'b11);
    check("pair_cnt_2", pair_cnt_o, 32'd2);
    check("wrap_pc", iss_pc_o, {39'h510, 39'h50c});
    check("wrap_v", iss_v_o, 2'b11);

    // Poison drops buffered and same-cycle entries.
    poison_i   = 1'b1;
    fe_v_i     = 2'b11;
    fe_pc_i    = {39'h604, 39'h600};
    fe_instr_i = {add_i(5'd1, 5'd2, 5'd3), add_i(5'd4, 5'd5, 5'd6)};
    #1;
    check("poison_comb_v", iss_v_o, 2'b00);
    tick();
    poison_i = 1'b0;
    fe_v_i   = 2'b00;
    check("poison_v", iss_v_o, 2'b00);
    check("poison_ready", fe_ready_o, 1'b1);
    push(2'b01, 39'h610, add_i(5'd1, 5'd2, 5'd3), 39'h0, 32'h0);
    check("poison_cnt1_v", iss_v_o, 2'b01);
    check("poison_cnt1_pc", iss_pc_o[VW-1:0], 39'h610);
    pop(2'b01);

    // Poison leaves WAIT.
    push(2'b01, 39'h700, csr_i, 39'h0, 32'h0);
    pop(2'b01);
    push(2'b01, 39'h704, add_i(5'd1, 5'd2, 5'd3), 39'h0, 32'h0);
    check("wait_v", iss_v_o, 2'b00);
    poison_i = 1'b1;
    tick();
    poison_i = 1'b0;
    push(2'b01, 39'h708, add_i(5'd1, 5'd2, 5'd3), 39'h0, 32'h0);
    check("poison_run_v", iss_v_o, 2'b01);
    check("poison_run_pc", iss_pc_o[VW-1:0], 39'h708);
    check("pair_cnt_kept", pair_cnt_o, 32'd2);
    pop(2'b01);

    // Asynchronous reset in WAIT with three entries buffered.
    push(2'b11, 39'h800, csr_i, 39'h804, add_i(5'd3, 5'd4, 5'd5));
    pop(2'b01);
    push(2'b11, 39'h808, add_i(5'd1, 5'd2, 5'd3), 39'h80c, add_i(5'd4, 5'd5, 5'd6));
    check("pre_rst_ready", fe_ready_o, 1'b0);
    check("pre_rst_v", iss_v_o, 2'b00);
    reset_i = 1'b1;
    #1;
    check("async_rst_v", iss_v_o, 2'b00);
    check("async_rst_ready", fe_ready_o, 1'b1);
    check("async_rst_pair_cnt", pair_cnt_o, 32'd0);
    tick();
    reset_i = 1'b0;
    tick();
    check("post_rst_v", iss_v_o, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
